im_loader: RTL and testbench

- Writer-side companion to the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 32-bit words.
- Each word is issued on a single-cycle write port into the instruction-memory array.
- It holds the CPU in reset while a load is in progress. It reports completion or a checksum/length error.
- It sits between the host/debug byte link and the instruction-memory write port.

---
 rtl/im_loader_if.sv | 27 ++
 rtl/im_loader.sv | 148 ++++++++++++++
 tb/tb_im_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the image loader.
// Latency: none, this is a plain signal bundle.
// Backpressure: in_ready from the loader qualifies in_valid/in_data from the host side.
interface im_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;

  // host / debug link side: drives the stream and the start pulse
  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done, error
  );

  // loader side
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done, error
  );
endinterface

// File: rtl/im_loader.sv
// Packs a length-prefixed, checksummed byte stream into 32-bit instruction-memory writes.
// Latency: we pulses the cycle after each word's 4th byte transfer; 1 word per 5 cycles sustained.
// Backpressure: in_ready is high only in LEN_HI/LEN_LO/DATA/CSUM; the write cycle stalls the stream.
module im_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input logic        clk,
  input logic        reset,
  im_loader_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CSUM   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // Largest legal word count; a full memory image is allowed.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic              we_q, we_d;
  logic [31:0]       waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer;
  logic [15:0]       len_full;
  logic [31:0]       shift_next;
  logic              last_word;

  assign bus.in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer       = bus.in_valid & bus.in_ready;
  assign len_full   = {len_q[15:8], bus.in_data};
  assign shift_next = {shift_q[23:0], bus.in_data};
  // Compared at full 16-bit width so a 2**ADDR_W-word image terminates on index 2**ADDR_W-1
  // even though word_idx itself wraps afterwards.
  assign last_word  = ({{(16-ADDR_W){1'b0}}, word_idx_q} == (len_q - 16'd1));

  assign bus.we    = we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.busy  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                     (state_q == S_WRITE)  || (state_q == S_CSUM);
  assign bus.done  = (state_q == S_DONE);
  assign bus.error = (state_q == S_ERR);

  // Next-state and datapath: advance only on accepted bytes, except the fixed one-cycle WRITE.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d    = S_LEN_HI;
          word_idx_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if ({1'b0, len_full} > CAP) begin
            state_d = S_ERR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          shift_d    = shift_next;
          csum_d     = csum_q ^ bus.in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Register the write port now so we/waddr/wdata are valid throughout WRITE.
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = shift_next;
            waddr_d = BASE_ADDR + {{(30-ADDR_W){1'b0}}, word_idx_q, 2'b00};
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + ADDR_W'(1);
        state_d    = last_word ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset discards any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= BASE_ADDR;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: driver pushes expected writes, monitor pops and compares.
// Latency: each expected write carries the cycle it must appear in.
// Backpressure: the driver holds each byte until it sees in_ready, with random idle gaps.
`timescale 1ns/1ps
module tb_im_loader;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  im_loader_if ifc();

  im_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] img [0:1023];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && ifc.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: addr %h data %h, no write expected", ifc.waddr, ifc.wdata);
      end else begin
        e = exp_q.pop_front();
        check("waddr", ifc.waddr, e.addr);
        check("wdata", ifc.wdata, e.data);
        check("we_cycle", cyc, e.cyc);
        check("in_ready_during_write", {31'd0, ifc.in_ready}, 32'd0);
      end
    end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_we: addr %h data %h expected in cycle %0d, write strobe absent", e.addr, e.data, e.cyc);
    end
  end

  // Present one byte (after optional random idle cycles) and hold it until accepted.
  // If it completes a word, the write it must cause is queued for the monitor.
  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit word_end,
                           input logic [31:0] waddr, input logic [31:0] wdata, output bit ok);
    wr_t e;
    ok = 1'b0;
    while ($urandom_range(99) < gap_pct) begin
      ifc.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ifc.in_ready === 1'b1) begin
        ok = 1'b1;
        if (word_end) begin
          e.addr = waddr;
          e.data = wdata;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL byte_accept_timeout: byte %h not accepted within 64 cycles", b);
    end
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
  endtask

  // One complete load of img[0..n-1]; expected outcome computed from the stream rules.
  task automatic run_load(input int n, input bit bad_csum, input int gap_pct, input bit start_mid);
    logic [15:0] n16;
    logic [7:0]  x;
    logic [7:0]  b;
    bit          ok;
    bit          overflow;
    n16      = 16'(n);
    x        = 8'h00;
    overflow = (n > (1 << ADDR_W));
    pulse_start();
    check("busy_after_start", {29'd0, ifc.busy, ifc.done, ifc.error}, 32'h4);
    send_byte(n16[15:8], gap_pct, 1'b0, 32'h0, 32'h0, ok);
    if (!ok) return;
    send_byte(n16[7:0], gap_pct, 1'b0, 32'h0, 32'h0, ok);
    if (!ok) return;
    if (!overflow) begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          b = img[i][31-8*j -: 8];
          x = x ^ b;
          if (start_mid && i == 0 && j == 1) ifc.start = 1'b1;
          send_byte(b, gap_pct, j == 3, BASE + 32'(i) * 32'd4, img[i], ok);
          ifc.start = 1'b0;
          if (!ok) return;
        end
      end
      send_byte(bad_csum ? (x ^ 8'h01) : x, gap_pct, 1'b0, 32'h0, 32'h0, ok);
      if (!ok) return;
    end
    @(posedge clk); #1;
    check("final_done",     {31'd0, ifc.done},     {31'd0, !(bad_csum || overflow)});
    check("final_error",    {31'd0, ifc.error},    {31'd0, (bad_csum || overflow)});
    check("final_busy",     {31'd0, ifc.busy},     32'd0);
    check("final_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("writes_drained", exp_q.size(),          32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #5ms;
    fails++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    bit ok;
    ifc.start    = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hA5;

    // Reset state, then idle with in_valid high and no start.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ifc.in_ready, ifc.we, ifc.busy, ifc.done, ifc.error}, 32'd0);
    check("reset_waddr", ifc.waddr, BASE);
    check("reset_wdata", ifc.wdata, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_outputs", {ifc.in_ready, ifc.we, ifc.busy, ifc.done, ifc.error}, 32'd0);
    check("idle_waddr", ifc.waddr, BASE);
    ifc.in_valid = 1'b0;

    // Two-word image: good checksum, bad checksum, then with random gaps.
    img[0] = 32'h3408_0001;
    img[1] = 32'hAC09_0000;
    run_load(2, 1'b0, 0, 1'b0);
    run_load(2, 1'b1, 0, 1'b0);
    run_load(2, 1'b0, 45, 1'b0);

    // Length overflow: 1025 words.
    run_load(1025, 1'b0, 0, 1'b0);

    // Empty image.
    run_load(0, 1'b0, 0, 1'b0);

    // Reset after two data bytes, then a fresh load must start at word 0.
    pulse_start();
    send_byte(8'h00, 0, 1'b0, 32'h0, 32'h0, ok);
    send_byte(8'h01, 0, 1'b0, 32'h0, 32'h0, ok);
    send_byte(8'hDE, 0, 1'b0, 32'h0, 32'h0, ok);
    send_byte(8'hAD, 0, 1'b0, 32'h0, 32'h0, ok);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {ifc.in_ready, ifc.we, ifc.busy, ifc.done, ifc.error}, 32'd0);
    check("midreset_waddr", ifc.waddr, BASE);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    img[0] = 32'h1234_5678;
    run_load(1, 1'b0, 0, 1'b0);

    // Randomized images, gaps, corrupt checksums, and a start pulse while busy.
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_load(n, ($urandom_range(0, 2) == 0), $urandom_range(0, 50), (t == 2));
    end

    // Full-capacity image: last write lands at the top word.
    for (int i = 0; i < 1024; i++) img[i] = $urandom;
    run_load(1024, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
